mmio_port: RTL and testbench

Memory-mapped I/O responder on the core's single-port memory bus. It claims every access with `address[11] == 1` (0x800–0xFFF) and provides:
- a byte transmit FIFO drained through a valid/ready stream;
- a status register, a GPIO output register and a free-running cycle counter;
- a halt/exit-code register at 0xFFC that ends a run.

It sits beside the main memory, with read data ORed into the core's `data_in`.

---
 rtl/mmio_port.sv | 131 +++++++++++++
 tb/tb_mmio_port.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_port.sv
// Memory-mapped I/O responder at 0x800-0xFFF: TX byte FIFO, status, GPIO, cycle counter, halt.
// Define MMIO_PORT_CYCLE_EN to build the free-running cycle counter readable at 0x808.
module mmio_port #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        we,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] gpio_out,
    output logic        halt,
    output logic [7:0]  exit_code
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [9:0] W_TXDATA = 10'h200;
    localparam logic [9:0] W_STATUS = 10'h201;
    localparam logic [9:0] W_CYCLE  = 10'h202;
    localparam logic [9:0] W_GPIO   = 10'h203;
    localparam logic [9:0] W_HALT   = 10'h3FF;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [31:0]   cycle_rd;

    logic       sel;
    logic [9:0] word;
    logic       wr;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push_req;
    logic       push;
    logic       ovf_set;
    logic       ovf_clr;
    logic       unused_addr;

    assign unused_addr = ^{address[31:12], address[1:0]};

    assign sel  = address[11];
    assign word = address[11:2];
    // Once halted, every bus write is ignored; the FIFO still drains.
    assign wr   = sel && we && !halt;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign pop      = tx_valid && tx_ready;
    assign tx_data  = empty ? '0 : mem[rd_ptr];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign push_req = wr && (word == W_TXDATA);
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = wr && (word == W_STATUS) && data_in[2];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            gpio_out  <= '0;
            halt      <= 1'b0;
            exit_code <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (wr && (word == W_GPIO)) begin
                gpio_out <= data_in;
            end
            if (wr && (word == W_HALT)) begin
                halt      <= 1'b1;
                exit_code <= data_in[7:0];
            end
        end
    end

`ifdef MMIO_PORT_CYCLE_EN
    logic [31:0] cycle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    assign cycle_rd = cycle;
`else
    assign cycle_rd = '0;
`endif

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (word)
                W_STATUS: data_out = {29'b0, overflow, full, empty};
                W_CYCLE:  data_out = cycle_rd;
                W_GPIO:   data_out = gpio_out;
                W_HALT:   data_out = {23'b0, halt, exit_code};
                default:  data_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_port.sv
// Scoreboard bench for mmio_port: queue-based reference model, directed scenarios plus random bus traffic.
module tb_mmio_port;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        we = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] gpio_out;
    logic        halt;
    logic [7:0]  exit_code;

    mmio_port #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .data_out(data_out), .we(we), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .gpio_out(gpio_out), .halt(halt), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  exp_q[$];
    int          mcount;
    bit          movf;
    bit          mhalt;
    logic [7:0]  mexit;
    logic [31:0] mgpio;
    logic [31:0] mcycle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!a[11]) return 32'h0;
        case (a[11:0] & 12'hFFC)
            12'h804: return {29'b0, movf, mcount == D, mcount == 0};
`ifdef MMIO_PORT_CYCLE_EN
            12'h808: return mcycle;
`endif
            12'h80C: return mgpio;
            12'hFFC: return {23'b0, mhalt, mexit};
            default: return 32'h0;
        endcase
    endfunction

    // Stream monitor: every handshake must deliver the oldest accepted byte.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) chk("tx_unexpected_byte", 32'(tx_data), 32'hXXXX_XXXX);
            else chk("tx_stream", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    // One bus cycle, called at posedge+1; checks at negedge, then advances the model.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                        input bit cc = 1'b0, input logic [31:0] cv = '0);
        bit pop, push, set, clr;
        address  = a;
        data_in  = d;
        we       = w;
        tx_ready = r;
        @(negedge clk);
        chk("data_out", data_out, model_rd(a));
        if (cc) chk("read_const", data_out, cv);
        chk("tx_valid", 32'(tx_valid), 32'(mcount != 0));
        if (mcount == 0) chk("tx_data_empty", 32'(tx_data), 32'h0);
        chk("gpio_out", gpio_out, mgpio);
        chk("halt", 32'(halt), 32'(mhalt));
        chk("exit_code", 32'(exit_code), 32'(mexit));
        pop  = (mcount > 0) && r;
        push = 1'b0;
        set  = 1'b0;
        clr  = 1'b0;
        if (!mhalt && a[11] && w) begin
            case (a[11:0] & 12'hFFC)
                12'h800: if (mcount < D || pop) begin push = 1'b1; exp_q.push_back(d[7:0]); end
                         else set = 1'b1;
                12'h804: clr = d[2];
                12'h80C: mgpio = d;
                12'hFFC: begin mhalt = 1'b1; mexit = d[7:0]; end
                default: ;
            endcase
        end
        mcount = mcount + int'(push) - int'(pop);
        if (set) movf = 1'b1;
        else if (clr) movf = 1'b0;
        @(posedge clk);
        #1;
        mcycle++;
    endtask

    // Asserted between edges: outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_exit", 32'(exit_code), 32'h0);
        exp_q.delete();
        mcount = 0;
        movf   = 1'b0;
        mhalt  = 1'b0;
        mexit  = '0;
        mgpio  = '0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mcycle = '0;
    endtask

    initial begin
        logic [31:0] bases [7] = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h00C, 32'hA00, 32'h7FC};
        repeat (2) @(posedge clk);
        #3;
        do_reset();

        // reset state and counter
        step(32'h804, 0, 0, 0, 1, 32'h1);
        for (int i = 0; i < 3; i++) step(32'h808, 0, 0, 0);

        // single byte
        step(32'h800, 32'h41, 1, 0);
        chk("single_tx_data", 32'(tx_data), 32'h41);
        step(32'h804, 0, 0, 1);
        step(32'h804, 0, 0, 0, 1, 32'h1);

        // fill and overflow
        for (int i = 0; i < 8; i++) step(32'h800, 32'(i), 1, 0);
        step(32'h804, 0, 0, 0, 1, 32'h2);
        step(32'h800, 32'h08, 1, 0);
        step(32'h804, 0, 0, 0, 1, 32'h6);
        for (int i = 0; i < 8; i++) step(32'h900, 0, 0, 1);
        step(32'h804, 0, 0, 0, 1, 32'h5);
        step(32'h804, 32'h4, 1, 0);
        step(32'h804, 0, 0, 0, 1, 32'h1);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) step(32'h800, 32'h10 + 32'(i), 1, 0);
        step(32'h800, 32'h18, 1, 1);
        step(32'h804, 0, 0, 0, 1, 32'h2);
        for (int i = 0; i < 8; i++) step(32'h900, 0, 0, 1);
        chk("full_pushpop_drained", 32'(exp_q.size()), 32'h0);

        // GPIO and decode
        step(32'h80C, 32'hDEADBEEF, 1, 0);
        step(32'h80C, 0, 0, 0, 1, 32'hDEADBEEF);
        step(32'h00C, 32'h1234, 1, 0, 1, 32'h0);
        step(32'h80C, 0, 0, 0, 1, 32'hDEADBEEF);

        // random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = bases[$urandom_range(0, 6)] | ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 3));
            if (i == 200) begin
                step(32'h800, 32'h77, 1, 0);
                do_reset();
            end
            step(a, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3));
        end
        for (int i = 0; i < 10; i++) step(32'h900, 0, 0, 1);
        chk("random_drained", 32'(exp_q.size()), 32'h0);

        // halt: first write wins, later writes ignored, FIFO still drains
        step(32'h80C, 32'h0, 1, 0);
        step(32'h800, 32'h61, 1, 0);
        step(32'h800, 32'h62, 1, 0);
        step(32'hFFC, 32'h2A, 1, 0);
        step(32'hFFC, 32'h55, 1, 0);
        step(32'h80C, 32'h1, 1, 0);
        step(32'hFFC, 0, 0, 0, 1, 32'h12A);
        chk("halt_exit_code", 32'(exit_code), 32'h2A);
        chk("halt_gpio", gpio_out, 32'h0);
        for (int i = 0; i < 3; i++) step(32'h900, 0, 0, 1);
        chk("halt_drained", 32'(exp_q.size()), 32'h0);
        chk("halt_tx_valid", 32'(tx_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
